// File: rtl/ksa_param.sv
// RC4 key-scheduling engine: optional S[i]=i fill, then the 256-iteration KSA swap loop.
// Latency: 256 fill cycles (if requested) + 256*(2*(RD_LAT+1)+2) loop cycles + 1 done cycle.
// Backpressure: en is accepted only while rdy=1; requests arriving while busy are dropped.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   en / rdy            start request / idle indication
//   key, init_en        secret key and fill request, both latched on the accepting edge
//   addr, rddata        single-port S-memory address and read data (RD_LAT-cycle read)
//   wrdata, wren        S-memory write data and one-cycle write strobe
module ksa_param #(
    parameter int KEY_BYTES = 3,
    parameter int RD_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [KEY_BYTES*8-1:0] key,
    input  logic                   init_en,
    output logic [7:0]             addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
);
    localparam int             KIW       = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIW-1:0] KIDX_LAST = KIW'(KEY_BYTES - 1);
    localparam logic [KIW-1:0] KIDX_ONE  = KIW'(1);
    localparam logic [1:0]     WAIT_LAST = 2'(RD_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_RD_I, S_WT_I, S_RD_J, S_WT_J, S_WR_J, S_WR_I, S_DONE
    } state_t;

    state_t                 state;
    logic [KEY_BYTES*8-1:0] key_q;
    logic [7:0]             i;
    logic [7:0]             j;
    logic [7:0]             si;
    logic [7:0]             sj;
    logic [KIW-1:0]         kidx;      // i mod KEY_BYTES, kept as its own wrapping counter
    logic [1:0]             wcnt;      // cycles spent in a read-wait state
    logic [7:0]             key_byte;
    logic [7:0]             j_next;

    // Key byte 0 is the most significant byte of the key vector.
    always_comb begin
        key_byte = 8'h00;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx == KIW'(k)) begin
                key_byte = key_q[KEY_BYTES*8-1-8*k -: 8];
            end
        end
    end

    // S[i] arrives on rddata in the last WT_I cycle, so the new j is formed straight
    // from it; that lets addr already point at S[j] for the whole RD_J cycle.
    assign j_next = j + rddata + key_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            rdy    <= 1'b1;
            wren   <= 1'b0;
            addr   <= 8'h00;
            wrdata <= 8'h00;
            i      <= 8'h00;
            j      <= 8'h00;
            si     <= 8'h00;
            sj     <= 8'h00;
            kidx   <= '0;
            wcnt   <= 2'd0;
            key_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        key_q  <= key;
                        rdy    <= 1'b0;
                        i      <= 8'h00;
                        j      <= 8'h00;
                        kidx   <= '0;
                        addr   <= 8'h00;
                        wrdata <= 8'h00;
                        if (init_en) begin
                            wren  <= 1'b1;
                            state <= S_FILL;
                        end else begin
                            state <= S_RD_I;
                        end
                    end
                end
                // i doubles as the fill counter; it is cleared again before the loop.
                S_FILL: begin
                    if (i == 8'hFF) begin
                        i     <= 8'h00;
                        j     <= 8'h00;
                        wren  <= 1'b0;
                        addr  <= 8'h00;
                        state <= S_RD_I;
                    end else begin
                        i      <= i + 8'd1;
                        addr   <= i + 8'd1;
                        wrdata <= i + 8'd1;
                    end
                end
                S_RD_I: begin
                    wcnt  <= 2'd0;
                    state <= S_WT_I;
                end
                S_WT_I: begin
                    if (wcnt == WAIT_LAST) begin
                        si    <= rddata;
                        j     <= j_next;
                        addr  <= j_next;
                        state <= S_RD_J;
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                S_RD_J: begin
                    wcnt  <= 2'd0;
                    state <= S_WT_J;
                end
                S_WT_J: begin
                    if (wcnt == WAIT_LAST) begin
                        sj     <= rddata;
                        wren   <= 1'b1;
                        addr   <= j;
                        wrdata <= si;
                        state  <= S_WR_J;
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                // When i==j both writes hit the same location with the same value.
                S_WR_J: begin
                    addr   <= i;
                    wrdata <= sj;
                    state  <= S_WR_I;
                end
                S_WR_I: begin
                    wren  <= 1'b0;
                    i     <= i + 8'd1;
                    addr  <= i + 8'd1;
                    kidx  <= (kidx == KIDX_LAST) ? '0 : kidx + KIDX_ONE;
                    state <= (i == 8'hFF) ? S_DONE : S_RD_I;
                end
                S_DONE: begin
                    rdy   <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    wren  <= 1'b0;
                    rdy   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ksa_param.sv
// Self-checking bench for ksa_param: two instances (3-byte key / 1-cycle read and
// 5-byte key / 2-cycle read), each with its own S memory model and write scoreboard.
module tb_ksa_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;

    logic        en_a = 1'b0, init_a = 1'b0, rdy_a, wren_a;
    logic [23:0] key_a = '0;
    logic [7:0]  addr_a, rddata_a, wrdata_a;
    logic        en_b = 1'b0, init_b = 1'b0, rdy_b, wren_b;
    logic [39:0] key_b = '0;
    logic [7:0]  addr_b, rddata_b, wrdata_b;

    ksa_param #(.KEY_BYTES(3), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .rdy(rdy_a), .key(key_a), .init_en(init_a),
        .addr(addr_a), .rddata(rddata_a), .wrdata(wrdata_a), .wren(wren_a));

    ksa_param #(.KEY_BYTES(5), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .rdy(rdy_b), .key(key_b), .init_en(init_b),
        .addr(addr_b), .rddata(rddata_b), .wrdata(wrdata_b), .wren(wren_b));

    // S memories: A returns data one cycle after addr, B two cycles after.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] rd_a, rd_b0, rd_b1;
    always @(posedge clk) begin
        if (wren_a) mem_a[addr_a] <= wrdata_a;
        rd_a <= mem_a[addr_a];
        if (wren_b) mem_b[addr_b] <= wrdata_b;
        rd_b0 <= mem_b[addr_b];
        rd_b1 <= rd_b0;
    end
    assign rddata_a = rd_a;
    assign rddata_b = rd_b1;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] q_a [$];
    logic [15:0] q_b [$];
    logic [7:0]  gold [256];
    int          wr_cnt_a = 0;
    int          wr_cnt_b = 0;
    logic [15:0] exp_wa, exp_wb;
    bit          have_a, have_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input bit sel, input logic [15:0] w);
        if (sel) q_b.push_back(w);
        else     q_a.push_back(w);
    endtask

    // Scoreboard: every S-memory write is popped and compared with the golden sequence.
    always @(negedge clk) begin
        if (wren_a === 1'b1) begin
            wr_cnt_a++;
            checks++;
            have_a = (q_a.size() != 0);
            exp_wa = have_a ? q_a.pop_front() : 16'h0000;
            assert (have_a && ({addr_a, wrdata_a} === exp_wa)) else begin
                errors++;
                $error("FAIL wr_a observed=%h expected=%h queued=%0d", {addr_a, wrdata_a}, exp_wa, have_a);
            end
        end
        if (wren_b === 1'b1) begin
            wr_cnt_b++;
            checks++;
            have_b = (q_b.size() != 0);
            exp_wb = have_b ? q_b.pop_front() : 16'h0000;
            assert (have_b && ({addr_b, wrdata_b} === exp_wb)) else begin
                errors++;
                $error("FAIL wr_b observed=%h expected=%h queued=%0d", {addr_b, wrdata_b}, exp_wb, have_b);
            end
        end
    end

    // Golden RC4 KSA; pushes the expected {addr,data} write stream and leaves final S in gold.
    task automatic gen_exp(input logic [39:0] kv, input int nb, input bit fill, input bit sel);
        logic [7:0] s [256];
        logic [7:0] j, t, ii;
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            ii = 8'(n);
            if (fill) begin
                s[n] = ii;
                push(sel, {ii, ii});
            end else begin
                s[n] = sel ? mem_b[n] : mem_a[n];
            end
        end
        for (int n = 0; n < 256; n++) begin
            ii = 8'(n);
            j = j + s[n] + kv[nb*8-1-8*(n%nb) -: 8];
            push(sel, {j, s[n]});
            push(sel, {ii, s[j]});
            t    = s[n];
            s[n] = s[j];
            s[j] = t;
        end
        for (int n = 0; n < 256; n++) gold[n] = s[n];
    endtask

    // One full run: accept, optional disturbance while busy, then cycle count and final S.
    task automatic run(input bit sel, input logic [39:0] kv, input int nb, input bit fill,
                       input int exp_cyc, input bit disturb, input string tag);
        int cyc;
        gen_exp(kv, nb, fill, sel);
        @(posedge clk); #1;
        if (sel) begin key_b = kv; init_b = fill; en_b = 1'b1; end
        else     begin key_a = kv[23:0]; init_a = fill; en_a = 1'b1; end
        @(posedge clk); #1;
        cyc   = 1;
        en_a  = 1'b0;
        en_b  = 1'b0;
        key_a = 24'($urandom);
        key_b = {8'($urandom), 32'($urandom)};
        while (((sel ? rdy_b : rdy_a) !== 1'b1) && cyc < 6000) begin
            if (disturb && cyc == 400) begin
                en_a   = 1'b1;
                key_a  = ~kv[23:0];
                init_a = ~fill;
            end else begin
                en_a = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        en_a = 1'b0;
        check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_q_empty"}, 32'(sel ? q_b.size() : q_a.size()), 32'd0);
        for (int n = 0; n < 256; n++) begin
            check($sformatf("%s_S%0d", tag, n), 32'(sel ? mem_b[n] : mem_a[n]), 32'(gold[n]));
        end
    endtask

    initial begin
        int cyc;
        int base;

        // Asynchronous reset asserted mid-cycle takes effect before the next edge.
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_rdy_a",  32'(rdy_a),  32'd1);
        check("rst_wren_a", 32'(wren_a), 32'd0);
        check("rst_addr_a", 32'(addr_a), 32'd0);
        check("rst_rdy_b",  32'(rdy_b),  32'd1);
        check("rst_wren_b", 32'(wren_b), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_rdy_a",  32'(rdy_a),  32'd1);
        check("rst_hold_wren_a", 32'(wren_a), 32'd0);
        #2 rst = 1'b0;

        // All-zero key with fill: 256 + 256*6 + 2 cycles.
        run(1'b0, 40'h00_0000_0000, 3, 1'b1, 1794, 1'b0, "t2");
        // Key with i==j iterations near the start.
        run(1'b0, 40'h00_0000_033C, 3, 1'b1, 1794, 1'b0, "t3");
        // Two-cycle read latency, 5-byte key: 8 cycles per iteration.
        run(1'b1, 40'h01_0203_0405, 5, 1'b1, 2306, 1'b0, "t4");
        // No fill: loop starts from the S left by the previous run; accepted right after rdy.
        run(1'b0, 40'h00_00A5_5A11, 3, 1'b0, 1538, 1'b0, "tnofill");
        // en pulse and key change while busy are ignored.
        run(1'b0, 40'h00_0012_3456, 3, 1'b1, 1794, 1'b1, "t5");

        // Reset just as iteration i=100 begins, then a clean restart.
        gen_exp(40'h00_0000_033C, 3, 1'b1, 1'b0);
        base = wr_cnt_a;
        @(posedge clk); #1;
        key_a = 24'h00033C; init_a = 1'b1; en_a = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0;
        cyc  = 0;
        while ((wr_cnt_a - base) < 456 && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t6_writes_before_rst", 32'(wr_cnt_a - base), 32'd456);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_rdy",  32'(rdy_a),  32'd1);
        check("t6_rst_wren", 32'(wren_a), 32'd0);
        check("t6_rst_addr", 32'(addr_a), 32'd0);
        base = wr_cnt_a;
        repeat (2) @(posedge clk);
        #2;
        check("t6_no_writes_in_rst", 32'(wr_cnt_a - base), 32'd0);
        rst = 1'b0;
        q_a.delete();
        run(1'b0, 40'h00_0000_033C, 3, 1'b1, 1794, 1'b0, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
